button_event_encoder: RTL and testbench

- Parametrised successor of the Simon Says button-to-code encoder.
- Clocked block: synchronises and debounces NUM_BTN raw Basys3 push-buttons, then detects press edges.
- Priority-encodes each press into a CODE_W-bit code, delivered by a valid/ready handshake to the game FSM.
- Sits between the board button pins and the Simon Says sequence checker; replaces the combinational level encoder.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/button_debounce.sv | 41 ++++
 rtl/button_event_encoder.sv | 114 +++++++++++
 tb/tb_button_event_encoder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says button path.
//   CLK_HZ       : board system clock frequency
//   BTN_*        : code values produced for each button channel
//   enc_state_t  : press-encoder FSM states
package simon_pkg;

  localparam int CLK_HZ = 100_000_000;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser followed by a stability counter.
//   clk, reset : system clock, synchronous active-high reset
//   btn_raw    : asynchronous raw button level
//   level      : debounced level; changes only after DEBOUNCE_CYCLES
//                consecutive cycles of disagreement with the synced input
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // last disagreeing cycle of the window: accept the new level
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Debounces NUM_BTN push-buttons, detects press edges and hands each press
// to the game FSM as a priority-encoded code over a valid/ready handshake.
//   clk, reset  : system clock, synchronous active-high reset
//   btn_raw     : raw button levels, bit i = channel i
//   code        : index of the pressed button, meaningful while code_valid
//   code_valid  : press pending; held until code_ready is seen
//   code_ready  : consumer accept
//   btn_level   : debounced button levels
//   overrun     : sticky; a press arrived while a code was still pending
//
// state    | meaning
// IDLE     | waiting for a press edge
// HOLD     | code presented, waiting for the handshake
// WAIT_REL | press consumed, waiting for every button to be released
module button_event_encoder
  import simon_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CODE_W          = $clog2(NUM_BTN),
  parameter int LOCKOUT         = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               overrun
);

  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] rise_r;

  enc_state_t        state, state_n;
  logic [CODE_W-1:0] code_n;
  logic              valid_n;
  logic              overrun_n;
  logic [CODE_W-1:0] win;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[g]),
      .level  (btn_level[g])
    );
  end

  // rise_r is registered so the press reaches the FSM one cycle after the
  // debounced edge, keeping the encoder off the debounce output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      rise_r  <= '0;
    end else begin
      level_q <= btn_level;
      rise_r  <= btn_level & ~level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      code_valid <= valid_n;
      overrun    <= overrun_n;
    end
  end

  always_comb begin
    win       = '0;
    state_n   = state;
    code_n    = code;
    valid_n   = code_valid;
    overrun_n = overrun;

    // scan downwards so the lowest set index is the last one written
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rise_r[i]) win = CODE_W'(i);
    end

    case (state)
      IDLE: begin
        if (|rise_r) begin
          code_n  = win;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // a press arriving here is lost even if the handshake completes now
        if (|rise_r) overrun_n = 1'b1;
        if (code_ready) begin
          valid_n = 1'b0;
          state_n = (LOCKOUT != 0) ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (btn_level == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_event_encoder.sv
module tb_button_event_encoder;

  localparam int NB  = 5;
  localparam int DB  = 4;
  localparam int CW  = 3;
  localparam int LAT = 2 + DB + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, btn_raw0;
  logic [CW-1:0] code, code0;
  logic          code_valid, code_valid0;
  logic          code_ready, code_ready0;
  logic [NB-1:0] btn_level, btn_level0;
  logic          overrun, overrun0;

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  int exp0_q[$];

  always #5 clk = ~clk;

  button_event_encoder #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CODE_W(CW), .LOCKOUT(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .code(code),
    .code_valid(code_valid), .code_ready(code_ready),
    .btn_level(btn_level), .overrun(overrun)
  );

  button_event_encoder #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CODE_W(CW), .LOCKOUT(0)
  ) dut0 (
    .clk(clk), .reset(reset), .btn_raw(btn_raw0), .code(code0),
    .code_valid(code_valid0), .code_ready(code_ready0),
    .btn_level(btn_level0), .overrun(overrun0)
  );

  // scoreboard: every accepted code is compared against the queued press
  always @(negedge clk) begin
    if (code_valid && code_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_lock unexpected event code=%0d", code);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(code) !== e) begin
          bad++;
          $display("FAIL sb_lock code got=%0d exp=%0d", code, e);
        end
      end
    end
    if (code_valid0 && code_ready0) begin
      total++;
      if (exp0_q.size() == 0) begin
        bad++;
        $display("FAIL sb_free unexpected event code=%0d", code0);
      end else begin
        int e;
        e = exp0_q.pop_front();
        if (int'(code0) !== e) begin
          bad++;
          $display("FAIL sb_free code got=%0d exp=%0d", code0, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // k = cycles until code_valid is seen, or -1 if the budget expires
  task automatic wait_valid(input bit sel, input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if ((sel ? code_valid0 : code_valid) === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic accept(input bit sel);
    if (sel) code_ready0 = 1'b1; else code_ready = 1'b1;
    step(1);
    code_ready  = 1'b0;
    code_ready0 = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = '0; btn_raw0 = '0; code_ready = 1'b0; code_ready0 = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    total++;
    if ({code_valid, code, btn_level, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_lock got v=%b c=%0d l=%b o=%b exp all 0",
               code_valid, code, btn_level, overrun);
    end
    total++;
    if ({code_valid0, code0, btn_level0, overrun0} !== '0) begin
      bad++;
      $display("FAIL reset_free got v=%b c=%0d l=%b o=%b exp all 0",
               code_valid0, code0, btn_level0, overrun0);
    end
  endtask

  task automatic test_basic();
    int  k;
    bit  again;
    btn_raw = 5'b00100;
    exp_q.push_back(2);
    wait_valid(1'b0, 20, k);
    total++;
    if (k !== LAT) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=%0d", k, LAT);
    end
    total++;
    if (code !== 3'd2) begin
      bad++;
      $display("FAIL basic_code got=%0d exp=2", code);
    end
    total++;
    if (btn_level !== 5'b00100) begin
      bad++;
      $display("FAIL basic_level got=%b exp=00100", btn_level);
    end
    step(3);
    total++;
    if (code_valid !== 1'b1 || code !== 3'd2) begin
      bad++;
      $display("FAIL basic_hold got v=%b c=%0d exp v=1 c=2", code_valid, code);
    end
    accept(1'b0);
    total++;
    if (code_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_clear got=%b exp=0", code_valid);
    end
    again = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (code_valid) again = 1'b1;
    end
    total++;
    if (again !== 1'b0) begin
      bad++;
      $display("FAIL basic_single_event got second=%b exp=0", again);
    end
    btn_raw = '0;
    step(12);
  endtask

  task automatic test_glitch();
    bit seen_v, seen_l;
    seen_v = 1'b0; seen_l = 1'b0;
    btn_raw = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (code_valid) seen_v = 1'b1;
      if (btn_level[0]) seen_l = 1'b1;
    end
    btn_raw = '0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (code_valid) seen_v = 1'b1;
      if (btn_level[0]) seen_l = 1'b1;
    end
    total++;
    if (seen_l !== 1'b0) begin
      bad++;
      $display("FAIL glitch_level got=%b exp=0", seen_l);
    end
    total++;
    if (seen_v !== 1'b0) begin
      bad++;
      $display("FAIL glitch_valid got=%b exp=0", seen_v);
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] pat [3] = '{5'b11000, 5'b10110, 5'b11111};
    int            win [3] = '{3, 1, 0};
    int  k;
    bit  again;
    for (int t = 0; t < 3; t++) begin
      btn_raw = pat[t];
      exp_q.push_back(win[t]);
      wait_valid(1'b0, 20, k);
      total++;
      if (k < 1 || code !== CW'(win[t])) begin
        bad++;
        $display("FAIL simul_code pat=%b got=%0d k=%0d exp=%0d", pat[t], code, k, win[t]);
      end
      accept(1'b0);
      again = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (code_valid) again = 1'b1;
      end
      total++;
      if (again !== 1'b0 || overrun !== 1'b0) begin
        bad++;
        $display("FAIL simul_single pat=%b got extra=%b ovr=%b exp 0 0", pat[t], again, overrun);
      end
      btn_raw = '0;
      step(12);
    end
  endtask

  task automatic test_overrun();
    int k;
    btn_raw0 = 5'b00010;
    exp0_q.push_back(1);
    wait_valid(1'b1, 20, k);
    total++;
    if (k < 1 || code0 !== 3'd1 || overrun0 !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first got c=%0d o=%b k=%0d exp c=1 o=0", code0, overrun0, k);
    end
    btn_raw0 = '0;
    step(10);
    btn_raw0 = 5'b10000;
    step(12);
    total++;
    if (overrun0 !== 1'b1) begin
      bad++;
      $display("FAIL ovr_flag got=%b exp=1", overrun0);
    end
    total++;
    if (code_valid0 !== 1'b1 || code0 !== 3'd1) begin
      bad++;
      $display("FAIL ovr_code_held got v=%b c=%0d exp v=1 c=1", code_valid0, code0);
    end
    accept(1'b1);
    step(4);
    total++;
    if (code_valid0 !== 1'b0 || overrun0 !== 1'b1) begin
      bad++;
      $display("FAIL ovr_after got v=%b o=%b exp v=0 o=1", code_valid0, overrun0);
    end
    btn_raw0 = '0;
    step(12);
  endtask

  task automatic test_lockout();
    int k;
    bit seen;
    btn_raw = 5'b00001;
    exp_q.push_back(0);
    wait_valid(1'b0, 20, k);
    total++;
    if (k < 1 || code !== 3'd0) begin
      bad++;
      $display("FAIL lock_up got c=%0d k=%0d exp c=0", code, k);
    end
    accept(1'b0);
    btn_raw = 5'b00011;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (code_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL lock_ignored got ev=%b o=%b exp 0 0", seen, overrun);
    end
    btn_raw = '0;
    step(12);
    btn_raw = 5'b00010;
    exp_q.push_back(1);
    wait_valid(1'b0, 20, k);
    total++;
    if (k !== LAT || code !== 3'd1) begin
      bad++;
      $display("FAIL lock_down got c=%0d k=%0d exp c=1 k=%0d", code, k, LAT);
    end
    accept(1'b0);
    btn_raw = '0;
    step(12);

    // same sequence without lockout: the second press is delivered
    btn_raw0 = 5'b00001;
    exp0_q.push_back(0);
    wait_valid(1'b1, 20, k);
    accept(1'b1);
    btn_raw0 = 5'b00011;
    exp0_q.push_back(1);
    wait_valid(1'b1, 20, k);
    total++;
    if (k < 1 || code0 !== 3'd1) begin
      bad++;
      $display("FAIL free_down_held got c=%0d k=%0d exp c=1", code0, k);
    end
    accept(1'b1);
    btn_raw0 = '0;
    step(12);
  endtask

  task automatic test_reset_mid();
    int k;
    btn_raw = 5'b00100;
    wait_valid(1'b0, 20, k);
    total++;
    if (k < 1 || code !== 3'd2) begin
      bad++;
      $display("FAIL rst_pre got c=%0d k=%0d exp c=2", code, k);
    end
    reset = 1'b1;
    step(1);
    total++;
    if ({code_valid, code, btn_level, overrun} !== '0) begin
      bad++;
      $display("FAIL rst_mid got v=%b c=%0d l=%b o=%b exp all 0",
               code_valid, code, btn_level, overrun);
    end
    reset = 1'b0;
    exp_q.push_back(2);
    wait_valid(1'b0, 20, k);
    total++;
    if (k !== LAT || code !== 3'd2) begin
      bad++;
      $display("FAIL rst_repress got c=%0d k=%0d exp c=2 k=%0d", code, k, LAT);
    end
    accept(1'b0);
    btn_raw = '0;
    step(12);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_simultaneous();
    test_overrun();
    test_lockout();
    test_reset_mid();
    step(2);
    total++;
    if (exp_q.size() !== 0 || exp0_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain got pending=%0d/%0d exp 0/0", exp_q.size(), exp0_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
